mastermind_game_ctrl: RTL and testbench

Game-state controller for the Mastermind board display. It turns debounced button pulses into peg edits on the current guess row and scores each submitted guess against a latched secret with a sequential scorer. It decides between continue, win and lose. It drives the 72-bit board bus, current attempt index and input-state flag consumed directly by the VGA board renderer, plus per-row feedback counts.

---
 rtl/mastermind_pkg.sv | 69 ++++++
 rtl/mastermind_if.sv | 30 +++
 rtl/mastermind_scorer.sv | 54 +++++
 rtl/mastermind_game_ctrl.sv | 131 +++++++++++++
 tb/tb_mastermind_game_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mastermind_pkg.sv
// Shared constants, types and peg/board helpers for the Mastermind game controller.
package mastermind_pkg;

   localparam int unsigned ROWS        = 6;
   localparam int unsigned COLS        = 4;
   localparam int unsigned PEG_W       = 3;
   localparam int unsigned ROW_W       = COLS * PEG_W;
   localparam int unsigned MAT_W       = ROWS * ROW_W;
   localparam int unsigned FB_W        = 6;
   localparam int unsigned FB_FLAT_W   = ROWS * FB_W;
   localparam int unsigned NUM_COLOURS = 6;

   typedef enum logic [2:0] {
      Empty, Red, Green, Blue, Yellow, Cyan, Magenta
   } colour_e;

   typedef enum logic [2:0] {
      StIdle, StInput, StCheck, StWin, StLose
   } state_e;

   function automatic logic [PEG_W-1:0] peg_up(input logic [PEG_W-1:0] p);
      if (p == Empty || p == Magenta) return Red;
      return p + 3'd1;
   endfunction

   function automatic logic [PEG_W-1:0] peg_down(input logic [PEG_W-1:0] p);
      if (p == Empty || p == Red) return Magenta;
      return p - 3'd1;
   endfunction

   function automatic logic row_full(input logic [ROW_W-1:0] row);
      logic full;
      full = 1'b1;
      for (int c = 0; c < COLS; c++) begin
         if (row[c*PEG_W +: PEG_W] == Empty) full = 1'b0;
      end
      return full;
   endfunction

   function automatic logic [ROW_W-1:0] get_row(input logic [MAT_W-1:0] m,
                                                input logic [2:0] r);
      return m[32'(r)*ROW_W +: ROW_W];
   endfunction

   function automatic logic [2:0] count_colour(input logic [ROW_W-1:0] row,
                                               input logic [2:0] k);
      logic [2:0] n;
      n = '0;
      for (int c = 0; c < COLS; c++) begin
         if (row[c*PEG_W +: PEG_W] == k) n = n + 3'd1;
      end
      return n;
   endfunction

   function automatic logic [2:0] count_exact(input logic [ROW_W-1:0] g,
                                              input logic [ROW_W-1:0] s);
      logic [2:0] n;
      n = '0;
      for (int c = 0; c < COLS; c++) begin
         if (g[c*PEG_W +: PEG_W] == s[c*PEG_W +: PEG_W]) n = n + 3'd1;
      end
      return n;
   endfunction

   function automatic logic [2:0] min_cnt(input logic [2:0] a, input logic [2:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/mastermind_if.sv
// Button/secret inputs and board/feedback/state outputs of the game controller.
interface mastermind_if;
   import mastermind_pkg::*;

   logic                 btn_left;
   logic                 btn_right;
   logic                 btn_up;
   logic                 btn_down;
   logic                 btn_enter;
   logic [ROW_W-1:0]     secret;
   logic [MAT_W-1:0]     matrix_flat;
   logic [FB_FLAT_W-1:0] fb_flat;
   logic [2:0]           guess_num;
   logic [1:0]           cursor;
   logic                 q_Input;
   logic                 q_Check;
   logic                 q_Win;
   logic                 q_Lose;

   modport master (
      output btn_left, btn_right, btn_up, btn_down, btn_enter, secret,
      input  matrix_flat, fb_flat, guess_num, cursor, q_Input, q_Check, q_Win, q_Lose
   );

   modport slave (
      input  btn_left, btn_right, btn_up, btn_down, btn_enter, secret,
      output matrix_flat, fb_flat, guess_num, cursor, q_Input, q_Check, q_Win, q_Lose
   );

endinterface

// File: rtl/mastermind_scorer.sv
// Sequential scorer: exact hits on the start edge, then one colour per cycle.
module mastermind_scorer
   import mastermind_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [ROW_W-1:0] i_guess,
   input  logic [ROW_W-1:0] i_secret,
   output logic             o_busy,
   output logic             o_done,
   output logic [2:0]       o_exact,
   output logic [2:0]       o_partial
);

   logic [2:0] r_phase;
   logic [2:0] r_exact;
   logic [2:0] r_total;
   logic       r_busy;
   logic       r_done;

   // r_phase names the colour to accumulate next; guess and secret are held stable by the caller.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase <= '0;
         r_exact <= '0;
         r_total <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_exact <= count_exact(i_guess, i_secret);
            r_total <= '0;
            r_phase <= 3'd1;
            r_busy  <= 1'b1;
         end else if (r_busy) begin
            r_total <= r_total + min_cnt(count_colour(i_guess, r_phase),
                                         count_colour(i_secret, r_phase));
            r_phase <= r_phase + 3'd1;
            if (r_phase == 3'(NUM_COLOURS)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_exact   = r_exact;
   assign o_partial = r_total - r_exact;

endmodule

// File: rtl/mastermind_game_ctrl.sv
// Mastermind game FSM: peg editing, guess submission, scoring handoff and win/lose.
module mastermind_game_ctrl #(
   parameter int unsigned ROWS = mastermind_pkg::ROWS,
   parameter int unsigned COLS = mastermind_pkg::COLS
) (
   input  logic        clk,
   input  logic        reset,
   mastermind_if.slave bus
);
   import mastermind_pkg::*;

   state_e               r_state;
   logic [MAT_W-1:0]     r_matrix;
   logic [FB_FLAT_W-1:0] r_fb;
   logic [2:0]           r_guess_num;
   logic [1:0]           r_cursor;
   logic [ROW_W-1:0]     r_secret;
   logic                 r_q_input;
   logic                 r_q_check;
   logic                 r_q_win;
   logic                 r_q_lose;

   logic [ROW_W-1:0]     w_row;
   logic [31:0]          w_peg_lsb;
   logic [PEG_W-1:0]     w_peg;
   logic                 w_start;
   logic                 w_busy;
   logic                 w_done;
   logic [2:0]           w_exact;
   logic [2:0]           w_partial;
   logic [1:0]           w_cur_max;

   assign w_row     = get_row(r_matrix, r_guess_num);
   assign w_peg_lsb = 32'(r_guess_num) * ROW_W + 32'(r_cursor) * PEG_W;
   assign w_peg     = r_matrix[w_peg_lsb +: PEG_W];
   assign w_start   = (r_state == StInput) && bus.btn_enter && row_full(w_row);
   assign w_cur_max = 2'(COLS - 1);

   mastermind_scorer u_scorer (
      .clk      (clk),
      .reset    (reset),
      .i_start  (w_start),
      .i_guess  (w_row),
      .i_secret (r_secret),
      .o_busy   (w_busy),
      .o_done   (w_done),
      .o_exact  (w_exact),
      .o_partial(w_partial)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= StIdle;
         r_matrix    <= '0;
         r_fb        <= '0;
         r_guess_num <= '0;
         r_cursor    <= '0;
         r_secret    <= '0;
         r_q_input   <= 1'b0;
         r_q_check   <= 1'b0;
         r_q_win     <= 1'b0;
         r_q_lose    <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_secret  <= bus.secret;
               r_state   <= StInput;
               r_q_input <= 1'b1;
            end
            StInput: begin
               // Enter with an incomplete row still blocks the lower-priority buttons.
               if (bus.btn_enter) begin
                  if (w_start) begin
                     r_state   <= StCheck;
                     r_q_input <= 1'b0;
                     r_q_check <= 1'b1;
                  end
               end else if (bus.btn_up) begin
                  r_matrix[w_peg_lsb +: PEG_W] <= peg_up(w_peg);
               end else if (bus.btn_down) begin
                  r_matrix[w_peg_lsb +: PEG_W] <= peg_down(w_peg);
               end else if (bus.btn_left) begin
                  r_cursor <= (r_cursor == 2'd0) ? w_cur_max : r_cursor - 2'd1;
               end else if (bus.btn_right) begin
                  r_cursor <= (r_cursor == w_cur_max) ? 2'd0 : r_cursor + 2'd1;
               end
            end
            StCheck: begin
               if (w_done && !w_busy) begin
                  r_fb[32'(r_guess_num) * FB_W +: FB_W] <= {w_partial, w_exact};
                  r_q_check <= 1'b0;
                  if (w_exact == 3'(COLS)) begin
                     r_state <= StWin;
                     r_q_win <= 1'b1;
                  end else if (r_guess_num == 3'(ROWS - 1)) begin
                     r_state  <= StLose;
                     r_q_lose <= 1'b1;
                  end else begin
                     r_guess_num <= r_guess_num + 3'd1;
                     r_cursor    <= '0;
                     r_state     <= StInput;
                     r_q_input   <= 1'b1;
                  end
               end
            end
            StWin, StLose: begin
               if (bus.btn_enter) begin
                  r_matrix    <= '0;
                  r_fb        <= '0;
                  r_guess_num <= '0;
                  r_cursor    <= '0;
                  r_q_win     <= 1'b0;
                  r_q_lose    <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.matrix_flat = r_matrix;
   assign bus.fb_flat     = r_fb;
   assign bus.guess_num   = r_guess_num;
   assign bus.cursor      = r_cursor;
   assign bus.q_Input     = r_q_input;
   assign bus.q_Check     = r_q_check;
   assign bus.q_Win       = r_q_win;
   assign bus.q_Lose      = r_q_lose;

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Randomized bench for mastermind_game_ctrl: board model plus a scoreboard for guess scoring.
module tb_mastermind_game_ctrl;
   import mastermind_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mastermind_if bus ();

   mastermind_game_ctrl dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      int         row;
      int         exact;
      int         partial;
      int         gn;
      logic [3:0] flags;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   bit   abort_check = 1'b0;

   // Model: 0 idle, 1 input, 3 win, 4 lose
   int m_mat[ROWS][COLS];
   int m_fb[ROWS];
   int m_gn;
   int m_cur;
   int m_st;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] flags();
      return {bus.q_Input, bus.q_Check, bus.q_Win, bus.q_Lose};
   endfunction

   function automatic logic [71:0] model_mat();
      logic [71:0] m;
      m = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) m[r*12 + c*3 +: 3] = 3'(m_mat[r][c]);
      return m;
   endfunction

   function automatic logic [35:0] model_fb();
      logic [35:0] f;
      f = '0;
      for (int r = 0; r < ROWS; r++) f[r*6 +: 6] = 6'(m_fb[r]);
      return f;
   endfunction

   function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
      return {3'(d), 3'(c), 3'(b), 3'(a)};
   endfunction

   function automatic logic [11:0] rand_code(input logic [11:0] avoid);
      logic [11:0] g;
      do begin
         for (int c = 0; c < COLS; c++) g[c*3 +: 3] = 3'($urandom_range(1, 6));
      end while (g == avoid);
      return g;
   endfunction

   // Mastermind scoring straight from the rules.
   task automatic score(input logic [11:0] g, input logic [11:0] s, output int ex, output int pa);
      int tot;
      ex  = 0;
      tot = 0;
      for (int c = 0; c < COLS; c++) if (g[c*3 +: 3] == s[c*3 +: 3]) ex++;
      for (int k = 1; k <= 6; k++) begin
         int cg = 0;
         int cs = 0;
         for (int c = 0; c < COLS; c++) begin
            if (int'(g[c*3 +: 3]) == k) cg++;
            if (int'(s[c*3 +: 3]) == k) cs++;
         end
         tot += (cg < cs) ? cg : cs;
      end
      pa = tot - ex;
   endtask

   function automatic void model_clear();
      for (int r = 0; r < ROWS; r++) begin
         m_fb[r] = 0;
         for (int c = 0; c < COLS; c++) m_mat[r][c] = 0;
      end
      m_gn  = 0;
      m_cur = 0;
   endfunction

   // b: 0 left, 1 right, 2 up, 3 down, 4 enter
   task automatic pulse(input int b);
      case (b)
         0: bus.btn_left  = 1'b1;
         1: bus.btn_right = 1'b1;
         2: bus.btn_up    = 1'b1;
         3: bus.btn_down  = 1'b1;
         default: bus.btn_enter = 1'b1;
      endcase
      @(posedge clk);
      #1;
      bus.btn_left  = 1'b0;
      bus.btn_right = 1'b0;
      bus.btn_up    = 1'b0;
      bus.btn_down  = 1'b0;
      bus.btn_enter = 1'b0;
   endtask

   task automatic press(input int b);
      int p;
      pulse(b);
      if (m_st == 1) begin
         p = m_mat[m_gn][m_cur];
         case (b)
            0: m_cur = (m_cur + COLS - 1) % COLS;
            1: m_cur = (m_cur + 1) % COLS;
            2: m_mat[m_gn][m_cur] = (p == 0 || p == 6) ? 1 : p + 1;
            default: m_mat[m_gn][m_cur] = (p <= 1) ? 6 : p - 1;
         endcase
      end
      check("matrix_edit", bus.matrix_flat, model_mat());
      check("cursor_edit", bus.cursor, m_cur);
   endtask

   task automatic set_peg(input int c, input int v);
      int lr = $urandom_range(0, 1);
      int ud = $urandom_range(2, 3);
      for (int i = 0; i < 8 && m_cur != c; i++) press(lr);
      for (int i = 0; i < 8 && m_mat[m_gn][c] != v; i++) press(ud);
   endtask

   task automatic do_enter();
      logic [11:0] g;
      bit          full;
      int          ex, pa;
      exp_t        e;
      full = 1'b1;
      for (int c = 0; c < COLS; c++) begin
         g[c*3 +: 3] = 3'(m_mat[m_gn][c]);
         if (m_mat[m_gn][c] == 0) full = 1'b0;
      end
      if (m_st == 1 && full) begin
         score(g, dut.r_secret, ex, pa);
         m_fb[m_gn] = pa * 8 + ex;
         e.row = m_gn;
         e.exact = ex;
         e.partial = pa;
         if (ex == 4) begin
            m_st = 3;
            e.flags = 4'b0010;
         end else if (m_gn == ROWS - 1) begin
            m_st = 4;
            e.flags = 4'b0001;
         end else begin
            m_gn++;
            m_cur = 0;
            e.flags = 4'b1000;
         end
         e.gn = m_gn;
         exp_q.push_back(e);
         pulse(4);
         pulse($urandom_range(0, 4));
         for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
         end
         check("score_done", exp_q.size(), 0);
         check("matrix_after", bus.matrix_flat, model_mat());
         check("cursor_after", bus.cursor, m_cur);
         check("fb_after", bus.fb_flat, model_fb());
      end else if (m_st == 1) begin
         pulse(4);
         check("enter_ignored", flags(), 4'b1000);
         @(posedge clk);
         #1;
         check("enter_ignored2", flags(), 4'b1000);
      end else begin
         pulse(4);
         model_clear();
         check("clear_flags", flags(), 4'b0000);
         check("clear_matrix", bus.matrix_flat, 72'd0);
         check("clear_fb", bus.fb_flat, 36'd0);
         check("clear_gn", {bus.guess_num, bus.cursor}, 5'd0);
         @(posedge clk);
         #1;
         m_st = 1;
         check("restart_input", flags(), 4'b1000);
      end
   endtask

   task automatic play(input logic [11:0] g);
      for (int c = 0; c < COLS; c++) set_peg(c, int'(g[c*3 +: 3]));
      do_enter();
   endtask

   // Scoreboard monitor: each completed CHECK pops one expected result.
   initial begin
      int   cyc;
      logic prev;
      exp_t e;
      cyc  = 0;
      prev = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (bus.q_Check) begin
            cyc++;
         end else if (prev) begin
            if (exp_q.size() == 0) begin
               if (!abort_check) check("unexpected_score", 1, 0);
            end else begin
               e = exp_q.pop_front();
               if (!abort_check) begin
                  check("check_cycles", cyc, 7);
                  check("fb_row", bus.fb_flat[e.row*6 +: 6], {3'(e.partial), 3'(e.exact)});
                  check("gn_after_check", bus.guess_num, e.gn);
                  check("flags_after_check", flags(), e.flags);
               end
            end
            cyc = 0;
         end
         prev = bus.q_Check;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] sec;
      bus.btn_left  = 1'b0;
      bus.btn_right = 1'b0;
      bus.btn_up    = 1'b0;
      bus.btn_down  = 1'b0;
      bus.btn_enter = 1'b0;
      sec = pk(1, 2, 3, 4);
      bus.secret = sec;
      model_clear();
      m_st = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_matrix", bus.matrix_flat, 72'd0);
      check("rst_fb", bus.fb_flat, 36'd0);
      check("rst_gn_cursor", {bus.guess_num, bus.cursor}, 5'd0);
      check("rst_flags", flags(), 4'b0000);
      reset = 1'b0;
      check("idle_cycle", flags(), 4'b0000);
      @(posedge clk);
      #1;
      check("input_after_idle", flags(), 4'b1000);
      m_st = 1;

      press(2); press(2);
      check("peg0_up_twice", bus.matrix_flat[2:0], 3'd2);
      press(1); press(3);
      check("peg1_down_from_empty", bus.matrix_flat[5:3], 3'd6);
      press(0); press(0);
      check("cursor_left_wrap", bus.cursor, 2'd3);

      set_peg(0, 1); set_peg(1, 3); set_peg(2, 2);
      do_enter();
      set_peg(3, 5);
      do_enter();
      check("g1_fb_row0", bus.fb_flat[5:0], {3'd2, 3'd1});
      check("g1_gn1", {bus.guess_num, bus.cursor}, {3'd1, 2'd0});

      play(rand_code(sec));
      play(rand_code(sec));
      play(sec);
      check("win_flag", flags(), 4'b0010);
      check("win_gn", bus.guess_num, 3'd3);
      press(2);
      press(1);

      sec = pk(1, 1, 2, 2);
      bus.secret = sec;
      do_enter();
      play(pk(1, 2, 1, 1));
      check("dup_fb_row0", bus.fb_flat[5:0], {3'd2, 3'd1});
      for (int i = 0; i < 5; i++) play(rand_code(sec));
      check("lose_flag", flags(), 4'b0001);
      check("lose_gn", bus.guess_num, 3'd5);
      press(3);

      sec = rand_code(12'd0);
      bus.secret = sec;
      do_enter();
      sec = rand_code(12'd0);
      for (int c = 0; c < COLS; c++) set_peg(c, int'(sec[c*3 +: 3]));
      pulse(4);
      check("check_started", flags(), 4'b0100);
      repeat (3) @(posedge clk);
      #1;
      abort_check = 1'b1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midcheck_rst_matrix", bus.matrix_flat, 72'd0);
      check("midcheck_rst_fb", bus.fb_flat, 36'd0);
      check("midcheck_rst_gn", {bus.guess_num, bus.cursor}, 5'd0);
      check("midcheck_rst_flags", flags(), 4'b0000);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("post_rst_input", flags(), 4'b1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
